// File: rtl/captura_numero_pkg.sv
// Shared definitions for the digit-capture block and the per-digit difference blocks.
package captura_numero_pkg;

  localparam int unsigned GRID    = 11;
  localparam int unsigned PIX_W   = 8;
  localparam int unsigned COORD_W = 10;
  localparam int unsigned IDX_W   = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    CAPTURE
  } estado_t;

endpackage

// File: rtl/captura_numero_acumulador_celula.sv
// One column accumulator: sums cell luma along a cell row and yields the truncating cell average.
module acumulador_celula
  import captura_numero_pkg::*;
#(
  parameter int unsigned LOG2_CELL = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             add,
  input  logic             close,
  input  logic [PIX_W-1:0] luma,
  output logic [PIX_W-1:0] media_c
);

  localparam int unsigned ACC_W = PIX_W + 2 * LOG2_CELL;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] base_c;
  logic [ACC_W-1:0] sum_c;

  // A clear coinciding with an add makes this pixel the first of the new frame.
  always_comb begin
    base_c  = clear ? '0 : acc;
    sum_c   = base_c + ACC_W'(luma);
    media_c = PIX_W'(sum_c >> (2 * LOG2_CELL));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (add) begin
      acc <= close ? '0 : sum_c;
    end else if (clear) begin
      acc <= '0;
    end
  end

endmodule

// File: rtl/captura_numero.sv
// Captures an 11x11 cell-averaged luma image of a screen window into numero, once per start.
module captura_numero
  import captura_numero_pkg::*;
#(
  parameter int unsigned X0        = 0,
  parameter int unsigned Y0        = 0,
  parameter int unsigned LOG2_CELL = 2
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic                                   frame_start,
  input  logic                                   pix_valid,
  input  logic [COORD_W-1:0]                     pix_x,
  input  logic [COORD_W-1:0]                     pix_y,
  input  logic [PIX_W-1:0]                       pix_luma,
  output logic [GRID-1:0][GRID-1:0][PIX_W-1:0]   numero,
  output logic                                   numero_valid,
  output logic                                   busy
);

  localparam int unsigned CELL = 1 << LOG2_CELL;
  localparam int unsigned WIN  = GRID * CELL;

  estado_t                             state;
  logic [GRID-1:0][GRID-1:0][PIX_W-1:0] shadow;
  logic [GRID-1:0][PIX_W-1:0]          media_c;
  logic [GRID-1:0]                     add_c;
  logic [COORD_W-1:0]                  dx_c;
  logic [COORD_W-1:0]                  dy_c;
  logic [IDX_W-1:0]                    col_c;
  logic [IDX_W-1:0]                    row_c;
  logic                                in_win_c;
  logic                                capturing_c;
  logic                                clear_c;
  logic                                accept_c;
  logic                                corner_c;
  logic                                last_c;

  // Window decode; the frame_start cycle out of WAIT_FRAME already accepts its pixel.
  always_comb begin
    dx_c        = pix_x - COORD_W'(X0);
    dy_c        = pix_y - COORD_W'(Y0);
    in_win_c    = (pix_x >= COORD_W'(X0)) && (dx_c < COORD_W'(WIN)) &&
                  (pix_y >= COORD_W'(Y0)) && (dy_c < COORD_W'(WIN));
    capturing_c = (state == CAPTURE) || ((state == WAIT_FRAME) && frame_start);
    clear_c     = frame_start && (state != IDLE);
    accept_c    = capturing_c && pix_valid && in_win_c;
    corner_c    = ((dx_c & COORD_W'(CELL - 1)) == COORD_W'(CELL - 1)) &&
                  ((dy_c & COORD_W'(CELL - 1)) == COORD_W'(CELL - 1));
    col_c       = IDX_W'(dx_c >> LOG2_CELL);
    row_c       = IDX_W'(dy_c >> LOG2_CELL);
    last_c      = accept_c && corner_c &&
                  (col_c == IDX_W'(GRID - 1)) && (row_c == IDX_W'(GRID - 1));
    add_c       = '0;
    if (accept_c) add_c[col_c] = 1'b1;
  end

  for (genvar c = 0; c < GRID; c++) begin : g_col
    acumulador_celula #(
      .LOG2_CELL (LOG2_CELL)
    ) u_acc (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear_c),
      .add     (add_c[c]),
      .close   (corner_c),
      .luma    (pix_luma),
      .media_c (media_c[c])
    );
  end

  // numero takes the shadow plus the just-finished last cell in one step, so it is never partial.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      numero_valid <= 1'b0;
      numero       <= '0;
      shadow       <= '0;
    end else begin
      numero_valid <= 1'b0;
      if (accept_c && corner_c) shadow[row_c][col_c] <= media_c[col_c];
      case (state)
        IDLE: begin
          if (start) begin
            state <= WAIT_FRAME;
            busy  <= 1'b1;
          end
        end
        WAIT_FRAME: begin
          if (frame_start) state <= CAPTURE;
        end
        CAPTURE: begin
          if (last_c) begin
            state                    <= IDLE;
            busy                     <= 1'b0;
            numero                   <= shadow;
            numero[GRID-1][GRID-1]   <= media_c[GRID-1];
            numero_valid             <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_captura_numero.sv
// Directed bench for captura_numero with default window (0,0) and 4x4 cells.
module tb_captura_numero;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    start;
  logic                    frame_start;
  logic                    pix_valid;
  logic [9:0]              pix_x;
  logic [9:0]              pix_y;
  logic [7:0]              pix_luma;
  logic [10:0][10:0][7:0]  numero;
  logic                    numero_valid;
  logic                    busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int vcount = 0;
  int valid_cyc = -1;
  int pix_cyc = -1;

  captura_numero dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .frame_start  (frame_start),
    .pix_valid    (pix_valid),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_luma     (pix_luma),
    .numero       (numero),
    .numero_valid (numero_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Pulse monitor sampled just after each active edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (numero_valid) begin
      vcount++;
      valid_cyc = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 2000000", $time);
    $fatal(1, "watchdog");
  end

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_fs();
    @(negedge clk); frame_start = 1'b1;
    @(negedge clk); frame_start = 1'b0;
  endtask

  // mode 0: constant val, 1: luma = x[7:0], 2: 0 inside 44x44 window else 255.
  task automatic send_rows(input int y_first, input int y_last, input int w, input int mode,
                           input int val, input bit fs_first, input int start_row);
    for (int y = y_first; y <= y_last; y++) begin
      for (int x = 0; x < w; x++) begin
        @(negedge clk);
        pix_valid   = 1'b1;
        pix_x       = 10'(x);
        pix_y       = 10'(y);
        frame_start = fs_first && (x == 0) && (y == y_first);
        start       = (y == start_row) && (x == 0);
        case (mode)
          0:       pix_luma = 8'(val);
          1:       pix_luma = 8'(x);
          default: pix_luma = (x < 44 && y < 44) ? 8'd0 : 8'd255;
        endcase
        if (x == 43 && y == 43) pix_cyc = cyc;
      end
    end
    @(negedge clk);
    pix_valid = 1'b0; frame_start = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); reset = 1'b1;
    idle_cycles(2);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (numero_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", numero_valid); end
    n_cmp++; if (numero !== '0) begin n_bad++; $display("FAIL reset_numero: got %h want 0", numero); end
  endtask

  task automatic test_uniform();
    vcount = 0;
    pulse_start();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL uniform_busy_armed: got %b want 1", busy); end
    pulse_fs();
    send_rows(0, 43, 44, 0, 100, 1'b0, -1);
    idle_cycles(3);
    for (int r = 0; r < 11; r++)
      for (int c = 0; c < 11; c++) begin
        n_cmp++;
        if (numero[r][c] !== 8'd100) begin
          n_bad++; $display("FAIL uniform_cell[%0d][%0d]: got %0d want 100", r, c, numero[r][c]);
        end
      end
    n_cmp++; if (vcount !== 1) begin n_bad++; $display("FAIL uniform_pulses: got %0d want 1", vcount); end
    n_cmp++; if (valid_cyc !== pix_cyc + 1) begin n_bad++; $display("FAIL uniform_latency: pulse cycle %0d want %0d", valid_cyc, pix_cyc + 1); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL uniform_busy_done: got %b want 0", busy); end
  endtask

  task automatic test_ramp();
    vcount = 0;
    pulse_start();
    pulse_fs();
    send_rows(0, 43, 44, 1, 0, 1'b0, -1);
    idle_cycles(3);
    for (int r = 0; r < 11; r++)
      for (int c = 0; c < 11; c++) begin
        n_cmp++;
        if (numero[r][c] !== 8'(4 * c + 1)) begin
          n_bad++; $display("FAIL ramp_cell[%0d][%0d]: got %0d want %0d", r, c, numero[r][c], 4 * c + 1);
        end
      end
    n_cmp++; if (vcount !== 1) begin n_bad++; $display("FAIL ramp_pulses: got %0d want 1", vcount); end
  endtask

  task automatic test_outside();
    vcount = 0;
    pulse_start();
    pulse_fs();
    send_rows(0, 47, 48, 2, 0, 1'b0, -1);
    idle_cycles(3);
    for (int r = 0; r < 11; r++)
      for (int c = 0; c < 11; c++) begin
        n_cmp++;
        if (numero[r][c] !== 8'd0) begin
          n_bad++; $display("FAIL outside_cell[%0d][%0d]: got %0d want 0", r, c, numero[r][c]);
        end
      end
    n_cmp++; if (vcount !== 1) begin n_bad++; $display("FAIL outside_pulses: got %0d want 1", vcount); end
  endtask

  // Abort at row 20; the restart frame_start coincides with its first pixel.
  task automatic test_abort();
    vcount = 0;
    pulse_start();
    pulse_fs();
    send_rows(0, 19, 44, 0, 7, 1'b0, -1);
    n_cmp++; if (vcount !== 0) begin n_bad++; $display("FAIL abort_no_pulse: got %0d want 0", vcount); end
    n_cmp++; if (numero !== '0) begin n_bad++; $display("FAIL abort_numero_held: got %h want 0", numero); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL abort_busy: got %b want 1", busy); end
    send_rows(0, 43, 44, 0, 50, 1'b1, -1);
    idle_cycles(3);
    for (int r = 0; r < 11; r++)
      for (int c = 0; c < 11; c++) begin
        n_cmp++;
        if (numero[r][c] !== 8'd50) begin
          n_bad++; $display("FAIL abort_cell[%0d][%0d]: got %0d want 50", r, c, numero[r][c]);
        end
      end
    n_cmp++; if (vcount !== 1) begin n_bad++; $display("FAIL abort_pulses: got %0d want 1", vcount); end
  endtask

  // start+frame_start together only arms; a start during capture is ignored.
  task automatic test_busy_start();
    vcount = 0;
    @(negedge clk); start = 1'b1; frame_start = 1'b1;
    @(negedge clk); start = 1'b0; frame_start = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_armed: got %b want 1", busy); end
    idle_cycles(2);
    pulse_fs();
    send_rows(0, 43, 44, 0, 30, 1'b0, 10);
    idle_cycles(3);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busy_after: got %b want 0", busy); end
    pulse_fs();
    send_rows(0, 43, 44, 0, 80, 1'b0, -1);
    idle_cycles(3);
    n_cmp++; if (vcount !== 1) begin n_bad++; $display("FAIL busy_pulses: got %0d want 1", vcount); end
    n_cmp++; if (numero[5][5] !== 8'd30) begin n_bad++; $display("FAIL busy_numero: got %0d want 30", numero[5][5]); end
    n_cmp++; if (numero[10][10] !== 8'd30) begin n_bad++; $display("FAIL busy_numero_last: got %0d want 30", numero[10][10]); end
  endtask

  task automatic test_reset_mid();
    vcount = 0;
    pulse_start();
    pulse_fs();
    send_rows(0, 24, 44, 0, 60, 1'b0, -1);
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    n_cmp++; if (numero !== '0) begin n_bad++; $display("FAIL rmid_numero: got %h want 0", numero); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
    send_rows(25, 43, 44, 0, 60, 1'b0, -1);
    pulse_fs();
    send_rows(0, 43, 44, 0, 60, 1'b0, -1);
    idle_cycles(3);
    n_cmp++; if (vcount !== 0) begin n_bad++; $display("FAIL rmid_no_pulse: got %0d want 0", vcount); end
    pulse_start();
    pulse_fs();
    send_rows(0, 43, 44, 0, 90, 1'b0, -1);
    idle_cycles(3);
    for (int r = 0; r < 11; r++)
      for (int c = 0; c < 11; c++) begin
        n_cmp++;
        if (numero[r][c] !== 8'd90) begin
          n_bad++; $display("FAIL rmid_cell[%0d][%0d]: got %0d want 90", r, c, numero[r][c]);
        end
      end
    n_cmp++; if (vcount !== 1) begin n_bad++; $display("FAIL rmid_pulses: got %0d want 1", vcount); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; frame_start = 1'b0; pix_valid = 1'b0;
    pix_x = '0; pix_y = '0; pix_luma = '0;
    test_reset();
    test_uniform();
    test_ramp();
    test_outside();
    test_abort();
    test_busy_start();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
